apb_mig_bridge: RTL and testbench

APB slave stage that consumes the APB transfers driven on the master side of the shared APB interface bundle and turns each one into a single Xilinx MIG user-interface (app_*) command.
It maps narrow APB words into lanes of the wide MIG data word: replicated write data with byte masks, and lane-selected read data.
It converts MIG handshakes and read latency into APB wait states, and reports protocol, calibration and timeout errors via PSLVERR.
One outstanding transfer at a time; sits between the APB fabric and the MIG core.

---
 rtl/apb_mig_bridge.sv | 255 +++++++++++++++++++++++++
 tb/tb_apb_mig_bridge.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mig_bridge.sv
// ---------------------------------------------------------------------------
// apb_mig_bridge
//
// APB slave that turns each APB transfer into exactly one MIG user-interface
// command. A narrow APB word is placed in one lane of the wide MIG data word:
// writes replicate the data and open only that lane's byte mask bits, and
// reads return that lane of the returned beat. Only one transfer is
// outstanding at a time. MIG handshakes and read latency become APB wait
// states. Protocol, calibration and read-timeout errors are reported on
// pslverr_o.
//
// Handshake semantics: a MIG command transfers on a rising edge where
// app_en_o & app_rdy_i. Write data transfers on an edge where
// app_wdf_wren_o & app_wdf_rdy_i. A valid stays asserted, with its payload
// unchanged, until that edge. It drops on the following cycle. The APB side
// completes on the single cycle in which pready_o is high.
//
// Ports:
//   pclk_i, preset_ni         clock, asynchronous active-low reset
//   paddr_i .. pstrb_i        APB completer inputs
//   prdata_o, pready_o,       APB completer outputs (all registered)
//   pslverr_o
//   app_addr_o, app_cmd_o,    MIG command channel
//   app_en_o, app_rdy_i
//   app_wdf_*                 MIG write-data channel (single beat)
//   app_rd_data_i,            MIG read-data channel
//   app_rd_data_valid_i
//   init_calib_complete_i     MIG calibration done
//   dbg_state_o               current FSM state, for debug and checkers
// ---------------------------------------------------------------------------
module apb_mig_bridge #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int APP_ADDR_W = 28,
  parameter int APP_DATA_W = 128,
  parameter int ADDR_SHIFT = 1,
  parameter int BURST_LSB  = 3,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    pclk_i,
  input  logic                    preset_ni,
  input  logic [ADDR_W-1:0]       paddr_i,
  input  logic [DATA_W-1:0]       pwdata_i,
  input  logic                    pwrite_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic [DATA_W/8-1:0]     pstrb_i,
  output logic [DATA_W-1:0]       prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  output logic [APP_ADDR_W-1:0]   app_addr_o,
  output logic [2:0]              app_cmd_o,
  output logic                    app_en_o,
  input  logic                    app_rdy_i,
  output logic [APP_DATA_W-1:0]   app_wdf_data_o,
  output logic [APP_DATA_W/8-1:0] app_wdf_mask_o,
  output logic                    app_wdf_wren_o,
  output logic                    app_wdf_end_o,
  input  logic                    app_wdf_rdy_i,
  input  logic [APP_DATA_W-1:0]   app_rd_data_i,
  input  logic                    app_rd_data_valid_i,
  input  logic                    init_calib_complete_i,
  output logic [2:0]              dbg_state_o
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int LANES    = APP_DATA_W / DATA_W;
  localparam int LANE_LSB = $clog2(STRB_W);
  localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W    = $clog2(TIMEOUT);

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_CMD,
    S_RD_WAIT,
    S_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic                    stale_q, stale_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [DATA_W-1:0]       prdata_d;
  logic                    pready_d, pslverr_d;
  logic [APP_ADDR_W-1:0]   app_addr_d;
  logic [2:0]              app_cmd_d;
  logic                    app_en_d;
  logic [APP_DATA_W-1:0]   app_wdf_data_d;
  logic [APP_DATA_W/8-1:0] app_wdf_mask_d;
  logic                    app_wdf_wren_d;

  // Start-of-transfer decode, computed from the live APB inputs.
  logic                    start;
  logic [ADDR_W-1:0]       shifted;
  logic                    err_misalign, err_range, err_any;
  logic [LANE_W-1:0]       lane_sel;
  logic [APP_ADDR_W-1:0]   addr_sel;
  logic [APP_DATA_W/8-1:0] mask_sel;
  logic [DATA_W-1:0]       rd_lane;

  always_comb begin
    start        = (state_q == S_IDLE) && psel_i && penable_i;
    shifted      = paddr_i >> ADDR_SHIFT;
    err_misalign = (paddr_i & ADDR_W'(STRB_W - 1)) != '0;
    // Any bit left above the MIG address width means out of range.
    err_range    = (shifted >> APP_ADDR_W) != '0;
    err_any      = err_misalign || err_range || !init_calib_complete_i;
    // The mask with LANES-1 gives lane 0 when there is a single lane.
    lane_sel     = LANE_W'(paddr_i >> LANE_LSB) & LANE_W'(LANES - 1);
    // Clear the burst-alignment bits by shifting them out and back in.
    addr_sel     = (APP_ADDR_W'(shifted) >> BURST_LSB) << BURST_LSB;
    mask_sel     = '1;
    mask_sel[lane_sel * STRB_W +: STRB_W] = ~pstrb_i;
    rd_lane      = app_rd_data_i[lane_q * DATA_W +: DATA_W];
  end

  always_comb begin
    state_d        = state_q;
    lane_d         = lane_q;
    stale_d        = stale_q;
    cnt_d          = cnt_q;
    prdata_d       = prdata_o;
    pready_d       = 1'b0;
    pslverr_d      = 1'b0;
    app_addr_d     = app_addr_o;
    app_cmd_d      = app_cmd_o;
    app_en_d       = app_en_o;
    app_wdf_data_d = app_wdf_data_o;
    app_wdf_mask_d = app_wdf_mask_o;
    app_wdf_wren_d = app_wdf_wren_o;

    // A late beat from a timed-out read is dropped in any state. Inside
    // RD_WAIT the stale beat is handled together with the new read's data.
    if (app_rd_data_valid_i && stale_q && (state_q != S_RD_WAIT)) begin
      stale_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (err_any) begin
            state_d   = S_RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = '0;
          end else begin
            lane_d     = lane_sel;
            app_addr_d = addr_sel;
            app_en_d   = 1'b1;
            if (pwrite_i) begin
              app_cmd_d      = CMD_WRITE;
              app_wdf_wren_d = 1'b1;
              app_wdf_data_d = {LANES{pwdata_i}};
              app_wdf_mask_d = mask_sel;
              state_d        = S_WR;
            end else begin
              app_cmd_d = CMD_READ;
              state_d   = S_RD_CMD;
            end
          end
        end
      end

      S_WR: begin
        // The command and data channels complete independently, in any order.
        app_en_d       = app_en_o & ~app_rdy_i;
        app_wdf_wren_d = app_wdf_wren_o & ~app_wdf_rdy_i;
        if (!app_en_d && !app_wdf_wren_d) begin
          state_d  = S_RESP;
          pready_d = 1'b1;
        end
      end

      S_RD_CMD: begin
        if (app_rdy_i) begin
          app_en_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (app_rd_data_valid_i && !stale_q) begin
          // A valid beat wins over a timeout that expires on the same cycle.
          prdata_d = rd_lane;
          state_d  = S_RESP;
          pready_d = 1'b1;
        end else begin
          if (app_rd_data_valid_i) begin
            stale_d = 1'b0;
          end
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // The beat may still arrive later. The stale flag drops it then.
            stale_d   = 1'b1;
            prdata_d  = '0;
            state_d   = S_RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      state_q        <= S_IDLE;
      lane_q         <= '0;
      stale_q        <= 1'b0;
      cnt_q          <= '0;
      prdata_o       <= '0;
      pready_o       <= 1'b0;
      pslverr_o      <= 1'b0;
      app_addr_o     <= '0;
      app_cmd_o      <= '0;
      app_en_o       <= 1'b0;
      app_wdf_data_o <= '0;
      app_wdf_mask_o <= '1;
      app_wdf_wren_o <= 1'b0;
      app_wdf_end_o  <= 1'b0;
    end else begin
      state_q        <= state_d;
      lane_q         <= lane_d;
      stale_q        <= stale_d;
      cnt_q          <= cnt_d;
      prdata_o       <= prdata_d;
      pready_o       <= pready_d;
      pslverr_o      <= pslverr_d;
      app_addr_o     <= app_addr_d;
      app_cmd_o      <= app_cmd_d;
      app_en_o       <= app_en_d;
      app_wdf_data_o <= app_wdf_data_d;
      app_wdf_mask_o <= app_wdf_mask_d;
      app_wdf_wren_o <= app_wdf_wren_d;
      app_wdf_end_o  <= app_wdf_wren_d;
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_mig_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_mig_bridge
//
// Self-checking bench for apb_mig_bridge, built with TIMEOUT = 16.
// - An APB driver issues one transfer at a time.
// - A MIG responder applies programmable ready holds and read latency.
// - A monitor checks every MIG command and write-data cycle against the
//   expected queues.
// A reference model predicts errors, the MIG address, lane, byte masks,
// latencies and read data. Memory is kept as an associative array of
// 128-bit words.
// ---------------------------------------------------------------------------
module tb_apb_mig_bridge;

  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic preset_ni = 1'b0;
  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [31:0]  paddr_i = '0;
  logic [31:0]  pwdata_i = '0;
  logic         pwrite_i = 1'b0;
  logic         psel_i = 1'b0;
  logic         penable_i = 1'b0;
  logic [3:0]   pstrb_i = '0;
  logic [31:0]  prdata_o;
  logic         pready_o, pslverr_o;
  logic [27:0]  app_addr_o;
  logic [2:0]   app_cmd_o;
  logic         app_en_o;
  logic         app_rdy_i = 1'b0;
  logic [127:0] app_wdf_data_o;
  logic [15:0]  app_wdf_mask_o;
  logic         app_wdf_wren_o, app_wdf_end_o;
  logic         app_wdf_rdy_i = 1'b0;
  logic [127:0] app_rd_data_i = '0;
  logic         app_rd_data_valid_i = 1'b0;
  logic         init_calib_complete_i = 1'b1;
  logic [2:0]   dbg_state;

  apb_mig_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .pclk_i(pclk), .preset_ni(preset_ni),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pwrite_i(pwrite_i),
    .psel_i(psel_i), .penable_i(penable_i), .pstrb_i(pstrb_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .app_addr_o(app_addr_o), .app_cmd_o(app_cmd_o), .app_en_o(app_en_o),
    .app_rdy_i(app_rdy_i), .app_wdf_data_o(app_wdf_data_o),
    .app_wdf_mask_o(app_wdf_mask_o), .app_wdf_wren_o(app_wdf_wren_o),
    .app_wdf_end_o(app_wdf_end_o), .app_wdf_rdy_i(app_wdf_rdy_i),
    .app_rd_data_i(app_rd_data_i), .app_rd_data_valid_i(app_rd_data_valid_i),
    .init_calib_complete_i(init_calib_complete_i), .dbg_state_o(dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model state ----------------
  logic [30:0]  exp_cmd_q[$];   // {cmd, app_addr}
  logic [143:0] exp_wdf_q[$];   // {mask, data}
  logic [127:0] mem [int];

  typedef struct {
    int           due;
    logic [127:0] data;
    bit           own;
  } beat_t;
  beat_t pend_q[$];

  int           rdy_hold = 0, wdf_hold = 0, rd_lat = 3;
  logic [127:0] rd_beat = '0;
  bit           rd_own = 1'b1;
  bit           mon_en = 1'b1;
  int           en_cnt = 0, wd_cnt = 0;
  int           last_en_len = 0, last_wd_len = 0;
  int           en_cycles = 0;
  int           rd_accept_cyc = 0;
  logic [2:0]   idle_state = '0;

  // ---------------- MIG responder + monitor (mid-cycle) ----------------
  always @(negedge pclk) begin
    beat_t b;
    app_rd_data_valid_i = 1'b0;
    for (int i = 0; i < pend_q.size(); i++) begin
      if (pend_q[i].due == cyc) begin
        app_rd_data_valid_i = 1'b1;
        app_rd_data_i       = pend_q[i].data;
        pend_q.delete(i);
        break;
      end
    end
    if (!preset_ni) begin
      app_rdy_i     = 1'b0;
      app_wdf_rdy_i = 1'b0;
      en_cnt        = 0;
      wd_cnt        = 0;
    end else begin
      if (app_en_o) begin
        app_rdy_i = (en_cnt >= rdy_hold);
        en_cnt++;
      end else begin
        app_rdy_i = 1'b0;
        if (en_cnt > 0) last_en_len = en_cnt;
        en_cnt = 0;
      end
      if (app_wdf_wren_o) begin
        app_wdf_rdy_i = (wd_cnt >= wdf_hold);
        wd_cnt++;
      end else begin
        app_wdf_rdy_i = 1'b0;
        if (wd_cnt > 0) last_wd_len = wd_cnt;
        wd_cnt = 0;
      end

      if (app_en_o) begin
        en_cycles++;
        if (app_rdy_i && app_cmd_o == 3'b001) begin
          b.due  = cyc + rd_lat;
          b.data = rd_beat;
          b.own  = rd_own;
          pend_q.push_back(b);
          rd_accept_cyc = cyc;
        end
        if (mon_en) begin
          check_eq("cmd_expected", exp_cmd_q.size() > 0, 1'b1);
          if (exp_cmd_q.size() > 0) begin
            check_eq("cmd_addr", {app_cmd_o, app_addr_o}, exp_cmd_q[0]);
            if (app_rdy_i) void'(exp_cmd_q.pop_front());
          end
        end
      end
      if (app_wdf_wren_o && mon_en) begin
        check_eq("wdf_expected", exp_wdf_q.size() > 0, 1'b1);
        if (exp_wdf_q.size() > 0) begin
          check_eq("wdf_end_mask_data", {app_wdf_end_o, app_wdf_mask_o, app_wdf_data_o},
                   {1'b1, exp_wdf_q[0]});
          if (app_wdf_rdy_i) void'(exp_wdf_q.pop_front());
        end
      end
    end
  end

  // ---------------- APB driver ----------------
  task automatic apb_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic err, output int lat, output int start_cyc);
    rdata = '0;
    err   = 1'b0;
    lat   = -1;
    @(posedge pclk); #1;
    paddr_i = addr; pwrite_i = wr; pwdata_i = wdata; pstrb_i = strb;
    psel_i = 1'b1; penable_i = 1'b0;
    @(posedge pclk); #1;
    penable_i = 1'b1;
    start_cyc = cyc;
    for (int k = 0; k < 200; k++) begin
      @(negedge pclk);
      if (pready_o) begin
        lat   = k;
        rdata = prdata_o;
        err   = pslverr_o;
        break;
      end
    end
    check_eq("pready_seen", lat >= 0, 1'b1);
    @(posedge pclk); #1;
    psel_i = 1'b0; penable_i = 1'b0;
    @(negedge pclk);
    check_eq("pready_pulse", pready_o, 1'b0);
    check_eq("back_to_idle", dbg_state, idle_state);
  endtask

  // ---------------- model-driven transfer ----------------
  task automatic do_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                         input logic [3:0] strb);
    bit           exp_err, exp_to;
    int           lane, lat, start_cyc, en_before, hold_max;
    logic [27:0]  waddr;
    logic [127:0] word, exp_data;
    logic [15:0]  exp_mask;
    logic [31:0]  rdata, exp_rd;
    logic         err;

    exp_err = (addr % 4 != 0) || ((addr >> 1) >= 32'h1000_0000) || !init_calib_complete_i;
    lane    = (addr / 4) % 4;
    waddr   = 28'(((addr >> 1) / 8) * 8);
    word    = mem.exists(int'(waddr)) ? mem[int'(waddr)] : '0;
    exp_to  = !wr && (rd_lat > TIMEOUT);

    if (!exp_err) begin
      exp_cmd_q.push_back({wr ? 3'b000 : 3'b001, waddr});
      if (wr) begin
        for (int b = 0; b < 16; b++) begin
          exp_data[b*8 +: 8] = wdata[(b % 4)*8 +: 8];
          exp_mask[b]        = (b / 4 == lane) ? !strb[b % 4] : 1'b1;
        end
        exp_wdf_q.push_back({exp_mask, exp_data});
      end
    end
    rd_own  = !exp_to;
    rd_beat = exp_to ? {4{32'hAAAA_AAAA}} : word;
    exp_rd  = (exp_err || exp_to) ? 32'h0 : word[lane*32 +: 32];
    en_before = en_cycles;
    hold_max  = (rdy_hold > wdf_hold) ? rdy_hold : wdf_hold;

    apb_xfer(addr, wr, wdata, strb, rdata, err, lat, start_cyc);

    check_eq("pslverr", err, exp_err || exp_to);
    if (exp_err) begin
      check_eq("err_latency", lat, 1);
      check_eq("err_no_app_en", en_cycles, en_before);
      if (!wr) check_eq("err_prdata", rdata, 32'h0);
    end else if (wr) begin
      check_eq("wr_latency", lat, 2 + hold_max);
      check_eq("wr_en_len", last_en_len, rdy_hold + 1);
      check_eq("wr_wren_len", last_wd_len, wdf_hold + 1);
      for (int b = 0; b < 4; b++)
        if (strb[b]) word[(lane*4 + b)*8 +: 8] = wdata[b*8 +: 8];
      mem[int'(waddr)] = word;
    end else begin
      check_eq("rd_data", rdata, exp_rd);
      check_eq("rd_en_len", last_en_len, rdy_hold + 1);
      if (exp_to) check_eq("timeout_latency", start_cyc + lat, rd_accept_cyc + TIMEOUT + 1);
      else        check_eq("rd_latency", start_cyc + lat, rd_accept_cyc + rd_lat + 1);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] a, wd;
    logic [3:0]  st;
    bit          wr, got_en;
    int          sel;

    // Reset state
    preset_ni = 1'b0;
    repeat (3) @(negedge pclk);
    check_eq("rst_outputs", {prdata_o, pready_o, pslverr_o, app_addr_o, app_cmd_o,
                             app_en_o, app_wdf_wren_o, app_wdf_end_o}, '0);
    check_eq("rst_wdf_data", app_wdf_data_o, '0);
    check_eq("rst_mask", app_wdf_mask_o, 16'hFFFF);
    idle_state = dbg_state;
    preset_ni = 1'b1;

    // 1. basic write, both ready immediately
    rdy_hold = 0; wdf_hold = 0;
    do_xfer(32'h14, 1'b1, 32'hDEADBEEF, 4'hF);

    // 2. basic read, lane 2, valid 3 cycles after accept
    mem[8] = 128'h44444444_33333333_22222222_11111111;
    rd_lat = 3;
    do_xfer(32'h18, 1'b0, 32'h0, 4'h0);

    // 3. backpressure on both write channels, then on a read command
    rdy_hold = 5; wdf_hold = 2;
    do_xfer(32'h24, 1'b1, 32'hCAFE_F00D, 4'b1010);
    rdy_hold = 4; wdf_hold = 0;
    do_xfer(32'h24, 1'b0, 32'h0, 4'h0);
    rdy_hold = 0;

    // 4. errors and the address range boundary
    do_xfer(32'h2, 1'b1, 32'h1234_5678, 4'hF);
    do_xfer(32'h2000_0000, 1'b0, 32'h0, 4'h0);
    do_xfer(32'h1FFF_FFFC, 1'b1, 32'h0BAD_BEEF, 4'hF);
    do_xfer(32'h1FFF_FFFC, 1'b0, 32'h0, 4'h0);
    init_calib_complete_i = 1'b0;
    do_xfer(32'h0, 1'b1, 32'h5555_AAAA, 4'hF);
    init_calib_complete_i = 1'b1;

    // 5. timeout boundaries and stale-beat discard
    rd_lat = TIMEOUT;     // valid on the last wait cycle still wins
    do_xfer(32'h18, 1'b0, 32'h0, 4'h0);
    rd_lat = TIMEOUT + 1; // timeout, late beat arrives in RESP
    do_xfer(32'h18, 1'b0, 32'h0, 4'h0);
    rd_lat = 26;          // timeout, late beat lands in the next read's wait
    do_xfer(32'h18, 1'b0, 32'h0, 4'h0);
    rd_lat = 8;
    do_xfer(32'h18, 1'b0, 32'h0, 4'h0);
    repeat (5) @(negedge pclk);

    // 6. reset asserted while app_en is high
    rdy_hold = 50; wdf_hold = 50; mon_en = 1'b0;
    @(posedge pclk); #1;
    paddr_i = 32'h40; pwrite_i = 1'b1; pwdata_i = 32'h1111_2222; pstrb_i = 4'hF;
    psel_i = 1'b1; penable_i = 1'b0;
    @(posedge pclk); #1;
    penable_i = 1'b1;
    got_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge pclk);
      if (app_en_o) begin
        got_en = 1'b1;
        break;
      end
    end
    check_eq("rst_mid_en_seen", got_en, 1'b1);
    #2 preset_ni = 1'b0;
    #1;
    check_eq("rst_mid_outputs", {prdata_o, pready_o, pslverr_o, app_addr_o, app_cmd_o,
                                 app_en_o, app_wdf_wren_o, app_wdf_end_o}, '0);
    check_eq("rst_mid_wdf_data", app_wdf_data_o, '0);
    check_eq("rst_mid_mask", app_wdf_mask_o, 16'hFFFF);
    psel_i = 1'b0; penable_i = 1'b0;
    repeat (2) @(negedge pclk);
    check_eq("rst_hold_pready", pready_o, 1'b0);
    preset_ni = 1'b1;
    rdy_hold = 0; wdf_hold = 0; mon_en = 1'b1; rd_lat = 2;
    do_xfer(32'h40, 1'b1, 32'h9876_5432, 4'hF);
    do_xfer(32'h40, 1'b0, 32'h0, 4'h0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      a   = 32'($urandom_range(0, 63)) * 4;
      if (sel == 0) a = a | 32'($urandom_range(1, 3));
      if (sel == 1) a = 32'h2000_0000 + a;
      init_calib_complete_i = (sel != 2);
      wr  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      st  = 4'($urandom_range(0, 15));
      rdy_hold = $urandom_range(0, 3);
      wdf_hold = $urandom_range(0, 3);
      rd_lat   = $urandom_range(1, 8);
      do_xfer(a, wr, wd, st);
      init_calib_complete_i = 1'b1;
    end

    repeat (4) @(negedge pclk);
    check_eq("cmd_q_drained", exp_cmd_q.size(), 0);
    check_eq("wdf_q_drained", exp_wdf_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
